// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: op codes, FSM encoding
// and small op-decoding helpers.
package alu_pkg;

  localparam logic [2:0] ALU_ID  = 3'd0;
  localparam logic [2:0] ALU_ADD = 3'd1;
  localparam logic [2:0] ALU_SUB = 3'd2;
  localparam logic [2:0] ALU_EQ  = 3'd3;
  localparam logic [2:0] ALU_LE  = 3'd4;
  localparam logic [2:0] ALU_GE  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  // Compare ops only define bit 0 of the ALU result.
  function automatic logic is_cmp(input logic [2:0] op);
    return (op == ALU_EQ) || (op == ALU_LE) || (op == ALU_GE);
  endfunction

  // Ops 6 and 7 have no ALU meaning and are flagged as errors.
  function automatic logic is_legal(input logic [2:0] op);
    return op <= ALU_GE;
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Command handshake bundle between a command source and the issue controller.
interface alu_issue_if #(
  parameter int DATA_WIDTH = 32,
  parameter int AW         = 4
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [2:0]            cmd_op;
  logic [AW-1:0]         cmd_rd;
  logic [AW-1:0]         cmd_rs0;
  logic [AW-1:0]         cmd_rs1;
  logic                  cmd_imm_en;
  logic [DATA_WIDTH-1:0] cmd_imm;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs0, cmd_rs1, cmd_imm_en, cmd_imm,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs0, cmd_rs1, cmd_imm_en, cmd_imm,
    output cmd_ready
  );
endinterface

// File: rtl/alu_regfile.sv
// Local register file: two asynchronous read ports, writeback and host write
// ports where writeback takes priority on an address collision; r0 reads zero.
module alu_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int NREG       = 16,
  parameter int AW         = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [AW-1:0]         rd_addr0,
  input  logic [AW-1:0]         rd_addr1,
  output logic [DATA_WIDTH-1:0] rd_data0,
  output logic [DATA_WIDTH-1:0] rd_data1,
  input  logic                  wb_en,
  input  logic [AW-1:0]         wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  host_en,
  input  logic [AW-1:0]         host_addr,
  input  logic [DATA_WIDTH-1:0] host_data
);

  logic [DATA_WIDTH-1:0] mem [NREG];

  // Storage update; the writeback assignment comes last so it overrides a
  // host write to the same register on the same edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else begin
      if (host_en && (host_addr != '0)) mem[host_addr] <= host_data;
      if (wb_en && (wb_addr != '0)) mem[wb_addr] <= wb_data;
    end
  end

  assign rd_data0 = (rd_addr0 == '0) ? '0 : mem[rd_addr0];
  assign rd_data1 = (rd_addr1 == '0) ? '0 : mem[rd_addr1];

endmodule

// File: rtl/alu_issue.sv
// Sequential ALU issue controller: accepts a command, presents operands to the
// external combinational ALU for one cycle, captures the result and writes it
// back, updating the condition flag for compares.
module alu_issue
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NREG       = 16,
  parameter int AW         = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  alu_issue_if.slave            cmd,
  output logic [2:0]            alu_ctrl,
  output logic [DATA_WIDTH-1:0] alu_in0,
  output logic [DATA_WIDTH-1:0] alu_in1,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic                  hw_en,
  input  logic [AW-1:0]         hw_addr,
  input  logic [DATA_WIDTH-1:0] hw_data,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  cond_flag
);

  state_t                state_q, state_d;
  logic [2:0]            op_q;
  logic [AW-1:0]         rd_q;
  logic [DATA_WIDTH-1:0] in0_q, in1_q, res_q;
  logic                  ready_q, cond_q;
  logic [DATA_WIDTH-1:0] rf_data0, rf_data1;
  logic                  accept, wb_we;

  assign accept = cmd.cmd_valid && ready_q;

  alu_regfile #(
    .DATA_WIDTH(DATA_WIDTH),
    .NREG      (NREG),
    .AW        (AW)
  ) u_regfile (
    .clk      (clk),
    .rstn     (rstn),
    .rd_addr0 (cmd.cmd_rs0),
    .rd_addr1 (cmd.cmd_rs1),
    .rd_data0 (rf_data0),
    .rd_data1 (rf_data1),
    .wb_en    (wb_we),
    .wb_addr  (rd_q),
    .wb_data  (res_q),
    .host_en  (hw_en),
    .host_addr(hw_addr),
    .host_data(hw_data)
  );

  // FSM state register; reset drops any in-flight command.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and per-state outputs: ALU control only during EXEC, done/err/
  // result and register write only during WB.
  always_comb begin
    state_d  = state_q;
    alu_ctrl = ALU_ID;
    done     = 1'b0;
    err      = 1'b0;
    res_data = '0;
    wb_we    = 1'b0;
    case (state_q)
      IDLE: if (accept) state_d = EXEC;
      EXEC: begin
        alu_ctrl = op_q;
        state_d  = WB;
      end
      WB: begin
        done    = 1'b1;
        state_d = IDLE;
        if (is_legal(op_q)) begin
          res_data = res_q;
          wb_we    = (rd_q != '0);
        end else begin
          err = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered ready: low from accept until the writeback edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                    ready_q <= 1'b0;
    else if (accept)                              ready_q <= 1'b0;
    else if ((state_q == IDLE) || (state_q == WB)) ready_q <= 1'b1;
  end

  // Operand latch at accept and result capture at the end of EXEC; compares
  // keep only bit 0 since the ALU leaves the upper bits undefined.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_q  <= ALU_ID;
      rd_q  <= '0;
      in0_q <= '0;
      in1_q <= '0;
      res_q <= '0;
    end else if (accept) begin
      op_q  <= cmd.cmd_op;
      rd_q  <= cmd.cmd_rd;
      in0_q <= rf_data0;
      in1_q <= cmd.cmd_imm_en ? cmd.cmd_imm : rf_data1;
    end else if (state_q == EXEC) begin
      res_q <= is_cmp(op_q) ? {{(DATA_WIDTH-1){1'b0}}, alu_out[0]} : alu_out;
    end
  end

  // Condition flag follows the most recent compare at its writeback.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                 cond_q <= 1'b0;
    else if ((state_q == WB) && is_cmp(op_q))  cond_q <= res_q[0];
  end

  assign cmd.cmd_ready = ready_q;
  assign alu_in0       = in0_q;
  assign alu_in1       = in1_q;
  assign cond_flag     = cond_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural ALU model attached.
module tb_alu_issue;
  import alu_pkg::*;

  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [2:0]    alu_ctrl;
  logic [DW-1:0] alu_in0, alu_in1, alu_out;
  logic          hw_en;
  logic [AW-1:0] hw_addr;
  logic [DW-1:0] hw_data;
  logic          done, err, cond_flag;
  logic [DW-1:0] res_data;
  logic          junk_le;

  int total = 0;
  int bad   = 0;

  logic [2:0]    ex_ctrl;
  logic [DW-1:0] ex_in0, ex_in1, wb_res;
  logic          ex_ready, wb_ready, wb_done, wb_err;
  int            last_wait;
  logic [DW-1:0] rval;

  alu_issue_if #(.DATA_WIDTH(DW), .AW(AW)) cmd_if ();

  alu_issue #(.DATA_WIDTH(DW), .NREG(16), .AW(AW)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .cmd      (cmd_if.slave),
    .alu_ctrl (alu_ctrl),
    .alu_in0  (alu_in0),
    .alu_in1  (alu_in1),
    .alu_out  (alu_out),
    .hw_en    (hw_en),
    .hw_addr  (hw_addr),
    .hw_data  (hw_data),
    .done     (done),
    .err      (err),
    .res_data (res_data),
    .cond_flag(cond_flag)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; compares return garbage upper bits on purpose.
  always_comb begin
    logic [DW-1:0] diff;
    diff    = alu_in0 - alu_in1;
    alu_out = '0;
    case (alu_ctrl)
      3'd0: alu_out = alu_in0;
      3'd1: alu_out = alu_in0 + alu_in1;
      3'd2: alu_out = diff;
      3'd3: alu_out = (alu_in0 == alu_in1) ? 32'hFFFF_FFFF : 32'hFFFF_FFFE;
      3'd4: alu_out = junk_le ? 32'hDEAD_BEE1 : {31'd0, diff[31]};
      3'd5: alu_out = {31'd0, diff[31]};
      default: alu_out = '0;
    endcase
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    hw_en = 1'b1; hw_addr = a; hw_data = d;
    tick;
    hw_en = 1'b0;
  endtask

  // One full command; snapshots EXEC and WB cycles, optional host write in WB.
  task automatic issue(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs0,
                       input logic [AW-1:0] rs1, input logic imm_en, input logic [DW-1:0] imm,
                       input logic conf_en, input logic [AW-1:0] conf_addr, input logic [DW-1:0] conf_data);
    last_wait = 0;
    while (!cmd_if.cmd_ready && last_wait < 20) begin
      tick;
      last_wait++;
    end
    if (!cmd_if.cmd_ready) begin
      total++; bad++;
      $display("[TB] FAIL ready_timeout: cmd_ready=%b required 1", cmd_if.cmd_ready);
    end
    cmd_if.cmd_op = op; cmd_if.cmd_rd = rd; cmd_if.cmd_rs0 = rs0; cmd_if.cmd_rs1 = rs1;
    cmd_if.cmd_imm_en = imm_en; cmd_if.cmd_imm = imm; cmd_if.cmd_valid = 1'b1;
    tick;
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_op = 3'd7; cmd_if.cmd_rd = 4'd15;
    cmd_if.cmd_rs0 = 4'd15; cmd_if.cmd_imm = 32'h1234_5678;
    ex_ctrl = alu_ctrl; ex_in0 = alu_in0; ex_in1 = alu_in1; ex_ready = cmd_if.cmd_ready;
    tick;
    wb_done = done; wb_err = err; wb_res = res_data; wb_ready = cmd_if.cmd_ready;
    if (conf_en) begin
      hw_en = 1'b1; hw_addr = conf_addr; hw_data = conf_data;
    end
    tick;
    hw_en = 1'b0;
  endtask

  task automatic read_reg(input logic [AW-1:0] r, output logic [DW-1:0] v);
    issue(ALU_ID, 4'd0, r, 4'd0, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
    v = wb_res;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({cmd_if.cmd_ready, done, err, cond_flag} !== 4'b0000) begin
      bad++; $display("[TB] FAIL reset_flags: got %b required 0000", {cmd_if.cmd_ready, done, err, cond_flag});
    end
    total++;
    if ({alu_ctrl, alu_in0, alu_in1, res_data} !== '0) begin
      bad++; $display("[TB] FAIL reset_buses: ctrl=%h in0=%h in1=%h res=%h required 0", alu_ctrl, alu_in0, alu_in1, res_data);
    end
    rstn = 1'b1;
    #1;
    total++;
    if (cmd_if.cmd_ready !== 1'b0) begin
      bad++; $display("[TB] FAIL ready_before_edge: got %b required 0", cmd_if.cmd_ready);
    end
    tick;
    total++;
    if (cmd_if.cmd_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL ready_after_release: got %b required 1", cmd_if.cmd_ready);
    end
    read_reg(4'd5, rval);
    total++;
    if (rval !== 32'd0) begin
      bad++; $display("[TB] FAIL reset_reg5: got %h required 0", rval);
    end
  endtask

  task automatic test_add;
    host_write(4'd1, 32'd5);
    host_write(4'd2, 32'd7);
    issue(ALU_ADD, 4'd3, 4'd1, 4'd2, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
    total++;
    if ({ex_ctrl, ex_in0, ex_in1} !== {3'd1, 32'd5, 32'd7}) begin
      bad++; $display("[TB] FAIL add_exec: ctrl=%h in0=%h in1=%h required 1/5/7", ex_ctrl, ex_in0, ex_in1);
    end
    total++;
    if ({ex_ready, wb_ready} !== 2'b00) begin
      bad++; $display("[TB] FAIL add_ready_busy: got %b required 00", {ex_ready, wb_ready});
    end
    total++;
    if ({wb_done, wb_err, wb_res} !== {1'b1, 1'b0, 32'd12}) begin
      bad++; $display("[TB] FAIL add_wb: done=%b err=%b res=%h required 1/0/c", wb_done, wb_err, wb_res);
    end
    total++;
    if ({done, cmd_if.cmd_ready} !== 2'b01) begin
      bad++; $display("[TB] FAIL add_after_wb: done/ready=%b required 01", {done, cmd_if.cmd_ready});
    end
    read_reg(4'd3, rval);
    total++;
    if (rval !== 32'd12) begin
      bad++; $display("[TB] FAIL add_r3: got %h required c", rval);
    end
  endtask

  task automatic test_wrap_cmp;
    host_write(4'd1, 32'd0);
    issue(ALU_SUB, 4'd3, 4'd1, 4'd0, 1'b1, 32'd1, 1'b0, 4'd0, 32'd0);
    total++;
    if (wb_res !== 32'hFFFF_FFFF) begin
      bad++; $display("[TB] FAIL sub_wrap: got %h required ffffffff", wb_res);
    end
    read_reg(4'd3, rval);
    total++;
    if (rval !== 32'hFFFF_FFFF) begin
      bad++; $display("[TB] FAIL sub_r3: got %h required ffffffff", rval);
    end
    host_write(4'd6, 32'd9);
    issue(ALU_EQ, 4'd7, 4'd6, 4'd0, 1'b1, 32'd9, 1'b0, 4'd0, 32'd0);
    total++;
    if ({wb_res, cond_flag} !== {32'd1, 1'b1}) begin
      bad++; $display("[TB] FAIL eq_masked: res=%h cond=%b required 1/1", wb_res, cond_flag);
    end
    host_write(4'd4, 32'h8000_0000);
    host_write(4'd5, 32'd1);
    issue(ALU_LE, 4'd3, 4'd4, 4'd5, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
    total++;
    if ({wb_res, cond_flag} !== {32'd0, 1'b0}) begin
      bad++; $display("[TB] FAIL le_nooverflow: res=%h cond=%b required 0/0", wb_res, cond_flag);
    end
  endtask

  task automatic test_cmp_mask;
    junk_le = 1'b1;
    issue(ALU_LE, 4'd3, 4'd6, 4'd5, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
    junk_le = 1'b0;
    total++;
    if ({wb_res, cond_flag} !== {32'd1, 1'b1}) begin
      bad++; $display("[TB] FAIL le_mask: res=%h cond=%b required 1/1", wb_res, cond_flag);
    end
    read_reg(4'd3, rval);
    total++;
    if (rval !== 32'd1) begin
      bad++; $display("[TB] FAIL le_mask_r3: got %h required 1", rval);
    end
  endtask

  task automatic test_illegal_r0;
    issue(3'd6, 4'd3, 4'd6, 4'd6, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
    total++;
    if ({wb_done, wb_err, wb_res} !== {1'b1, 1'b1, 32'd0}) begin
      bad++; $display("[TB] FAIL illegal_wb: done=%b err=%b res=%h required 1/1/0", wb_done, wb_err, wb_res);
    end
    total++;
    if (cond_flag !== 1'b1) begin
      bad++; $display("[TB] FAIL illegal_cond: got %b required 1", cond_flag);
    end
    read_reg(4'd3, rval);
    total++;
    if (rval !== 32'd1) begin
      bad++; $display("[TB] FAIL illegal_nowrite: got %h required 1", rval);
    end
    issue(ALU_ADD, 4'd0, 4'd6, 4'd0, 1'b1, 32'd5, 1'b0, 4'd0, 32'd0);
    total++;
    if (wb_res !== 32'd14) begin
      bad++; $display("[TB] FAIL r0_res: got %h required e", wb_res);
    end
    read_reg(4'd0, rval);
    total++;
    if (rval !== 32'd0) begin
      bad++; $display("[TB] FAIL r0_zero: got %h required 0", rval);
    end
  endtask

  task automatic test_conflict;
    host_write(4'd1, 32'd1);
    issue(ALU_ADD, 4'd3, 4'd1, 4'd0, 1'b1, 32'd3, 1'b1, 4'd3, 32'hAA);
    read_reg(4'd3, rval);
    total++;
    if (rval !== 32'd4) begin
      bad++; $display("[TB] FAIL wb_over_host: got %h required 4", rval);
    end
  endtask

  task automatic test_back_to_back;
    issue(ALU_ADD, 4'd8, 4'd3, 4'd0, 1'b1, 32'd1, 1'b0, 4'd0, 32'd0);
    issue(ALU_ADD, 4'd9, 4'd8, 4'd0, 1'b1, 32'd1, 1'b0, 4'd0, 32'd0);
    total++;
    if ({last_wait, wb_res} !== {32'd0, 32'd6}) begin
      bad++; $display("[TB] FAIL back_to_back: wait=%0d res=%h required 0/6", last_wait, wb_res);
    end
  endtask

  task automatic test_abort;
    host_write(4'd3, 32'h55);
    cmd_if.cmd_op = ALU_ADD; cmd_if.cmd_rd = 4'd3; cmd_if.cmd_rs0 = 4'd3;
    cmd_if.cmd_imm_en = 1'b1; cmd_if.cmd_imm = 32'd1; cmd_if.cmd_valid = 1'b1;
    tick;
    cmd_if.cmd_valid = 1'b0;
    total++;
    if ({alu_ctrl, alu_in0} !== {3'd1, 32'h55}) begin
      bad++; $display("[TB] FAIL abort_exec: ctrl=%h in0=%h required 1/55", alu_ctrl, alu_in0);
    end
    rstn = 1'b0;
    #1;
    total++;
    if ({done, err, cmd_if.cmd_ready, alu_ctrl, alu_in0, alu_in1} !== '0) begin
      bad++; $display("[TB] FAIL abort_outputs: done=%b err=%b ready=%b ctrl=%h in0=%h in1=%h required 0",
                      done, err, cmd_if.cmd_ready, alu_ctrl, alu_in0, alu_in1);
    end
    tick;
    tick;
    total++;
    if ({done, res_data, cond_flag} !== '0) begin
      bad++; $display("[TB] FAIL abort_held: done=%b res=%h cond=%b required 0", done, res_data, cond_flag);
    end
    rstn = 1'b1;
    tick;
    read_reg(4'd3, rval);
    total++;
    if (rval !== 32'd0) begin
      bad++; $display("[TB] FAIL abort_r3: got %h required 0", rval);
    end
    read_reg(4'd6, rval);
    total++;
    if (rval !== 32'd0) begin
      bad++; $display("[TB] FAIL abort_r6: got %h required 0", rval);
    end
  endtask

  initial begin
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_op = 3'd0; cmd_if.cmd_rd = '0;
    cmd_if.cmd_rs0 = '0; cmd_if.cmd_rs1 = '0; cmd_if.cmd_imm_en = 1'b0; cmd_if.cmd_imm = '0;
    hw_en = 1'b0; hw_addr = '0; hw_data = '0; junk_le = 1'b0;
    $display("[TB] starting alu_issue bench");
    test_reset;
    test_add;
    test_wrap_cmp;
    test_cmp_mask;
    test_illegal_r0;
    test_conflict;
    test_back_to_back;
    test_abort;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
